lsu_req_ctrl: RTL
=================

Name: lsu_req_ctrl

Overview:
CPU-side initiator for the load/store VALID/READY handshake; the peripheral/data-memory LSU is the responder.
- Takes the memory-stage access (funct3, byte address, rs2 data) and issues exactly one handshake transaction per access.
- Drives a word-aligned address, replicated store data and byte strobes.
- Stalls the pipeline until READY is sampled, then aligns and sign/zero-extends load data for writeback.
- Detects misaligned/illegal accesses and bus timeouts.

Parameters:
TIMEOUT_CYC, 255, number of BUSY cycles without READY before the transaction aborts (1..65535).

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_req  in  1  memory-stage access present; held until o_stall low
i_is_store  in  1  1 = store, 0 = load
i_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
i_addr  in  32  byte address (rs1+imm)
i_rs2_data  in  32  store source
o_lsu_addr  out  32  {addr[31:2],2'b00}
o_st_data  out  32  lane-replicated store data
o_st_strb  out  4  byte strobes (all 0 on loads)
o_lsu_wren  out  1  1 on store transactions
o_VALID  out  1  request valid
i_READY  in  1  responder ready
i_ld_data  in  32  responder read data, valid when i_READY
o_stall  out  1  pipeline hold
o_rd_data  out  32  extended load result
o_rd_vld  out  1  one-cycle completion pulse
o_misaligned  out  1  one-cycle pulse: misaligned or illegal funct3
o_bus_err  out  1  one-cycle pulse: timeout abort

Behaviour:
- Reset: all registered outputs 0, state IDLE, timeout counter 0. Reset mid-transaction aborts it: o_VALID is 0 in the cycle after the reset edge, and no o_rd_vld or error pulse is produced.
- FSM states: IDLE, BUSY, RESP.
  - IDLE & i_req & legal → BUSY. Address, data, strobe, wren and funct3 are captured on this edge; o_VALID=1 from the next cycle.
  - IDLE & i_req & illegal → RESP with o_misaligned=1, no VALID.
    - Illegal: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0; load funct3 ∈ {3,6,7}; store funct3 > 2.
  - BUSY & i_READY (sampled at the edge) → RESP. i_ld_data is captured on this edge.
  - BUSY & ~i_READY & cnt==TIMEOUT_CYC-1 → RESP with o_bus_err=1. o_VALID drops; this is the only permitted VALID drop without READY besides reset.
  - RESP → IDLE unconditionally.
- Handshake rules:
  - o_VALID is registered.
  - Address, data, strobe and wren are stable while o_VALID=1.
  - Exactly one READY acceptance per access.
  - i_READY in IDLE/RESP is ignored.
- o_stall = i_req & (state≠RESP), combinational. In RESP, o_stall=0 and the instruction retires at the end of that cycle.
- Minimum latency with READY already high: i_req at cycle N; VALID at N+1; o_rd_vld at N+2; stall high N and N+1.
- o_rd_vld pulses in RESP only for successful loads. It is 0 for stores and errors. o_rd_data is held until the next load completes.
- Store lane mapping:
  - SB: data={4{rs2[7:0]}}, strb=4'b0001<<addr[1:0].
  - SH: data={2{rs2[15:0]}}, strb=addr[1]?4'b1100:4'b0011.
  - SW: data=rs2, strb=4'b1111.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Timeout counter: width $clog2(TIMEOUT_CYC+1). Cleared on BUSY entry; increments each BUSY cycle with ~i_READY.
- READY coinciding with the final timeout cycle: success wins.

Decomposition:
- singlecycle_pkg gains:
  - mem_funct3_e enum: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB/SH/SW share 0/1/2.
  - lsu_state_e {IDLE, BUSY, RESP}.
- One sub-module: ld_align — combinational load lane select and extend (i_data, i_offset[1:0], i_funct3 → o_data).

Test Plan:
1. SB, addr 0x0000_2003, rs2 0x1234_56AB, READY tied high → cycle N+1: o_lsu_addr 0x0000_2000, o_st_data 0xABAB_ABAB, o_st_strb 4'b1000, wren 1; stall high N..N+1, low at N+2; o_rd_vld stays 0.
2. Loads from addr offset 2 with i_ld_data 0x8001_1234: LH → 0xFFFF_8001; LHU → 0x0000_8001. LB offset 0 with data 0x0000_0080 → 0xFFFF_FF80. LW → 0x8001_1234. o_rd_vld pulses once per load.
3. LW with READY delayed 3 cycles (SRAM) → VALID high 4 cycles, address stable throughout, single rd_vld, stall released the cycle after acceptance.
4. LW addr 0x0000_2002 and load funct3=3 → no VALID ever; o_misaligned pulses the cycle after i_req; stall high exactly 1 cycle.
5. TIMEOUT_CYC=8, READY held low → VALID high 8 cycles, then o_bus_err pulse and VALID 0. Repeat with READY arriving on the 8th cycle → success, no bus_err.
6. i_rst asserted on the 2nd BUSY cycle → o_VALID 0 next cycle, all outputs 0, no pulses; a following SW executes normally.

Source files
------------

// File: rtl/singlecycle_pkg.sv
// ============================================================================
// singlecycle_pkg : shared types for the single-cycle core memory stage
// Rev 1.0 - load/store request controller types and legality check
// ============================================================================
`default_nettype none

package singlecycle_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd4,
    LHU = 3'd5
  } mem_funct3_e;

  // Store encodings share the low load encodings.
  localparam logic [2:0] SB = 3'd0;
  localparam logic [2:0] SH = 3'd1;
  localparam logic [2:0] SW = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  function automatic logic is_illegal(input logic is_store, input logic [2:0] funct3,
                                      input logic [1:0] offset);
    logic ill;
    ill = 1'b1;
    if (is_store) begin
      case (funct3)
        SB:      ill = 1'b0;
        SH:      ill = offset[0];
        SW:      ill = |offset;
        default: ill = 1'b1;
      endcase
    end else begin
      case (funct3)
        LB, LBU: ill = 1'b0;
        LH, LHU: ill = offset[0];
        LW:      ill = |offset;
        default: ill = 1'b1;
      endcase
    end
    return ill;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ld_align.sv
// ============================================================================
// ld_align : load lane select and sign/zero extension
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module ld_align
  import singlecycle_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_data[7:0];
    case (i_offset)
      2'd1:    w_byte = i_data[15:8];
      2'd2:    w_byte = i_data[23:16];
      2'd3:    w_byte = i_data[31:24];
      default: w_byte = i_data[7:0];
    endcase
    w_half = i_offset[1] ? i_data[31:16] : i_data[15:0];

    o_data = i_data;
    case (i_funct3)
      LB:      o_data = {{24{w_byte[7]}}, w_byte};
      LH:      o_data = {{16{w_half[15]}}, w_half};
      LBU:     o_data = {24'd0, w_byte};
      LHU:     o_data = {16'd0, w_half};
      default: o_data = i_data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_req_ctrl.sv
// ============================================================================
// lsu_req_ctrl : CPU-side VALID/READY initiator for load/store accesses
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_req_ctrl
  import singlecycle_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_rs2_data,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_st_data,
  output logic [3:0]  o_st_strb,
  output logic        o_lsu_wren,
  output logic        o_VALID,
  input  logic        i_READY,
  input  logic [31:0] i_ld_data,
  output logic        o_stall,
  output logic [31:0] o_rd_data,
  output logic        o_rd_vld,
  output logic        o_misaligned,
  output logic        o_bus_err
);

  localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_e         r_state;
  lsu_state_e         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_funct3;
  logic [1:0]         r_offset;
  logic               r_is_store;
  logic               w_illegal;
  logic               w_accept;
  logic               w_timeout;
  logic [31:0]        w_ld_aligned;
  logic [31:0]        w_st_data;
  logic [3:0]         w_st_strb;

  assign w_illegal = is_illegal(i_is_store, i_funct3, i_addr[1:0]);
  assign w_accept  = (r_state == BUSY) && i_READY;
  assign w_timeout = (r_state == BUSY) && !i_READY && (r_cnt == c_CNT_LAST);
  assign o_stall   = i_req && (r_state != RESP);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_req) w_state_nxt = w_illegal ? RESP : BUSY;
      BUSY:    if (w_accept || w_timeout) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_st_data = i_rs2_data;
    w_st_strb = 4'b1111;
    case (i_funct3[1:0])
      2'b00: begin
        w_st_data = {4{i_rs2_data[7:0]}};
        w_st_strb = 4'b0001 << i_addr[1:0];
      end
      2'b01: begin
        w_st_data = {2{i_rs2_data[15:0]}};
        w_st_strb = i_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_st_data = i_rs2_data;
        w_st_strb = 4'b1111;
      end
    endcase
  end

  ld_align u_ld_align (
    .i_data   (i_ld_data),
    .i_offset (r_offset),
    .i_funct3 (r_funct3),
    .o_data   (w_ld_aligned)
  );

  // Request fields are only loaded from IDLE, so they stay frozen while VALID is up.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_lsu_addr   <= '0;
      o_st_data    <= '0;
      o_st_strb    <= '0;
      o_lsu_wren   <= 1'b0;
      o_VALID      <= 1'b0;
      o_rd_data    <= '0;
      o_rd_vld     <= 1'b0;
      o_misaligned <= 1'b0;
      o_bus_err    <= 1'b0;
      r_cnt        <= '0;
      r_funct3     <= '0;
      r_offset     <= '0;
      r_is_store   <= 1'b0;
    end else begin
      o_rd_vld     <= 1'b0;
      o_misaligned <= 1'b0;
      o_bus_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_req) begin
            if (w_illegal) begin
              o_misaligned <= 1'b1;
            end else begin
              o_lsu_addr <= {i_addr[31:2], 2'b00};
              o_st_data  <= w_st_data;
              o_st_strb  <= i_is_store ? w_st_strb : 4'b0000;
              o_lsu_wren <= i_is_store;
              o_VALID    <= 1'b1;
              r_funct3   <= i_funct3;
              r_offset   <= i_addr[1:0];
              r_is_store <= i_is_store;
              r_cnt      <= '0;
            end
          end
        end
        BUSY: begin
          if (i_READY) begin
            o_VALID <= 1'b0;
            if (!r_is_store) begin
              o_rd_data <= w_ld_aligned;
              o_rd_vld  <= 1'b1;
            end
          end else if (r_cnt == c_CNT_LAST) begin
            o_VALID   <= 1'b0;
            o_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
